led_chaser: RTL and testbench

Parametrised LED pattern sequencer for the board LED bank. It drives NUM_LEDS outputs with one of four run-time selectable patterns: rotate up, rotate down, bounce, and blink-all. It steps at a rate set by an internal prescaler. It runs entirely in the system clock domain: the step rate comes from a one-cycle clock-enable strobe, never a derived clock. It sits directly between the top level and the LED pins.

---
 rtl/led_pkg.sv | 34 +++
 rtl/led_chaser_if.sv | 26 ++
 rtl/led_tick_gen.sv | 37 +++
 rtl/led_chaser.sv | 174 +++++++++++++++++
 tb/tb_led_chaser.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// FSM state type and small elaboration/datapath helpers.
package led_pkg;

    // Pattern select encodings as presented on the mode input
    localparam logic [1:0] LED_ROT_UP   = 2'd0;
    localparam logic [1:0] LED_ROT_DOWN = 2'd1;
    localparam logic [1:0] LED_BOUNCE   = 2'd2;
    localparam logic [1:0] LED_BLINK    = 2'd3;

    // Pattern FSM states; encodings deliberately equal the mode codes so a
    // sampled mode can be loaded straight into the state register.
    typedef enum logic [1:0] {
        ST_ROT_UP   = LED_ROT_UP,
        ST_ROT_DOWN = LED_ROT_DOWN,
        ST_BOUNCE   = LED_BOUNCE,
        ST_BLINK    = LED_BLINK
    } led_state_e;

    // Width of the LED position index; never narrower than one bit so a
    // single-LED build still has a legal (constant zero) index register.
    function automatic int led_pos_width(input int num_leds);
        int w;
        w = $clog2(num_leds);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot decode of a position into the widest supported LED bank;
    // callers truncate to their own bank width.
    function automatic logic [31:0] led_onehot(input logic [4:0] pos);
        return 32'd1 << pos;
    endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Control/status bundle between the top level and the LED sequencer:
// pattern select and pause in, LED drive and step strobe out.
interface led_chaser_if #(
    parameter int NUM_LEDS = 4
);
    logic [1:0]          mode;
    logic                pause;
    logic [NUM_LEDS-1:0] led;
    logic                step;

    // Board top level: selects the pattern, observes the LEDs
    modport master (
        output mode,
        output pause,
        input  led,
        input  step
    );

    // Sequencer side
    modport slave (
        input  mode,
        input  pause,
        output led,
        output step
    );
endinterface

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: produces a one-cycle clock-enable every DIV enabled
// cycles. The counter freezes while en is low, so a suppressed step is
// simply delayed to the first enabled cycle rather than lost.
module led_tick_gen #(
    parameter int DIV = 2_500_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    output logic tick
);
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             at_last_s;

    assign at_last_s = (cnt_r == CNT_LAST);

    // The strobe is combinational so the consumer commits its update on
    // the same edge the counter wraps.
    assign tick = en && at_last_s;

    // Prescaler counter: wrap on a tick, advance when enabled, else hold
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led_chaser.sv
// LED pattern sequencer. A prescaler strobe advances one of four patterns
// (rotate up, rotate down, bounce, blink). The FSM state is the committed
// mode; a mode change is only taken on a step and loads that mode's start
// pattern directly, so there is never a blank step in between.
module led_chaser
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int DIV            = 2_500_000,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         nrst,
    led_chaser_if.slave  bus
);
    localparam int                  POS_W    = led_pos_width(NUM_LEDS);
    localparam logic [POS_W-1:0]    LAST_POS = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    ZERO_POS = {POS_W{1'b0}};
    localparam logic [NUM_LEDS-1:0] ALL_OFF  = {NUM_LEDS{1'b0}};
    localparam logic [NUM_LEDS-1:0] ALL_ON   = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] INV_MASK = (LED_ACTIVE_LOW != 0) ? ALL_ON : ALL_OFF;

    // Reject unsupported builds at elaboration
    if ((NUM_LEDS < 1) || (NUM_LEDS > 32)) begin : g_bad_num_leds
        $error("led_chaser: NUM_LEDS must be within 1..32");
    end
    if (DIV < 1) begin : g_bad_div
        $error("led_chaser: DIV must be at least 1");
    end

    led_state_e          state_r;
    led_state_e          state_n;
    logic [NUM_LEDS-1:0] pat_r;
    logic [NUM_LEDS-1:0] pat_n;
    logic [POS_W-1:0]    pos_r;
    logic [POS_W-1:0]    pos_n;
    logic                dir_r;
    logic                dir_n;
    logic [NUM_LEDS-1:0] led_r;
    logic                step_r;
    logic                tick_s;
    logic                mode_change_s;
    logic                first_step_s;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .en   (!bus.pause),
        .tick (tick_s)
    );

    assign mode_change_s = tick_s && (bus.mode != state_r);

    // After reset the pattern is empty; the first rotate step shows the
    // current position instead of advancing past it. Blink legitimately
    // passes through an all-off pattern, so it is excluded.
    assign first_step_s = (pat_r == ALL_OFF) && (state_r != ST_BLINK);

    // FSM state register: committed pattern mode
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_ROT_UP;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state: sample the requested mode only on a step
    always_comb begin
        state_n = state_r;
        if (tick_s) begin
            state_n = led_state_e'(bus.mode);
        end else begin
            state_n = state_r;
        end
    end

    // FSM output: next pattern, position and bounce direction
    always_comb begin
        pat_n = pat_r;
        pos_n = pos_r;
        dir_n = dir_r;
        if (!tick_s) begin
            pat_n = pat_r;
        end else if (mode_change_s) begin
            case (state_n)
                ST_ROT_UP: begin
                    pos_n = ZERO_POS;
                    pat_n = NUM_LEDS'(led_onehot(5'(ZERO_POS)));
                end
                ST_ROT_DOWN: begin
                    pos_n = LAST_POS;
                    pat_n = NUM_LEDS'(led_onehot(5'(LAST_POS)));
                end
                ST_BOUNCE: begin
                    pos_n = ZERO_POS;
                    dir_n = 1'b0;
                    pat_n = NUM_LEDS'(led_onehot(5'(ZERO_POS)));
                end
                ST_BLINK: begin
                    pat_n = ALL_ON;
                end
                default: begin
                    pat_n = pat_r;
                end
            endcase
        end else if (first_step_s) begin
            pat_n = NUM_LEDS'(led_onehot(5'(pos_r)));
        end else begin
            case (state_r)
                ST_ROT_UP: begin
                    if (pos_r == LAST_POS) begin
                        pos_n = ZERO_POS;
                    end else begin
                        pos_n = pos_r + POS_W'(1'b1);
                    end
                    pat_n = NUM_LEDS'(led_onehot(5'(pos_n)));
                end
                ST_ROT_DOWN: begin
                    if (pos_r == ZERO_POS) begin
                        pos_n = LAST_POS;
                    end else begin
                        pos_n = pos_r - POS_W'(1'b1);
                    end
                    pat_n = NUM_LEDS'(led_onehot(5'(pos_n)));
                end
                ST_BOUNCE: begin
                    // The direction flips on the step that lands on an end,
                    // so the end LED is shown exactly once per sweep.
                    if (NUM_LEDS == 1) begin
                        pos_n = ZERO_POS;
                        dir_n = 1'b0;
                    end else if (!dir_r) begin
                        pos_n = pos_r + POS_W'(1'b1);
                        dir_n = (pos_n == LAST_POS);
                    end else begin
                        pos_n = pos_r - POS_W'(1'b1);
                        dir_n = (pos_n != ZERO_POS);
                    end
                    pat_n = NUM_LEDS'(led_onehot(5'(pos_n)));
                end
                ST_BLINK: begin
                    pat_n = ~pat_r;
                end
                default: begin
                    pat_n = pat_r;
                end
            endcase
        end
    end

    // Pattern datapath registers plus registered LED drive and step strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pat_r  <= ALL_OFF;
            pos_r  <= ZERO_POS;
            dir_r  <= 1'b0;
            led_r  <= INV_MASK;
            step_r <= 1'b0;
        end else begin
            pat_r  <= pat_n;
            pos_r  <= pos_n;
            dir_r  <= dir_n;
            led_r  <= pat_n ^ INV_MASK;
            step_r <= tick_s;
        end
    end

    assign bus.led  = led_r;
    assign bus.step = step_r;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: five builds exercising rotate, bounce,
// blink with pause, active-low drive with async reset, and a single LED.
module tb_led_chaser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst_a, nrst_b, nrst_c, nrst_d, nrst_e;
    int   n_checks = 0;
    int   n_errors = 0;

    led_chaser_if #(.NUM_LEDS(4)) if_a ();
    led_chaser_if #(.NUM_LEDS(5)) if_b ();
    led_chaser_if #(.NUM_LEDS(4)) if_c ();
    led_chaser_if #(.NUM_LEDS(4)) if_d ();
    led_chaser_if #(.NUM_LEDS(1)) if_e ();

    led_chaser #(.NUM_LEDS(4), .DIV(3), .LED_ACTIVE_LOW(0)) u_a (.clk(clk), .nrst(nrst_a), .bus(if_a));
    led_chaser #(.NUM_LEDS(5), .DIV(1), .LED_ACTIVE_LOW(0)) u_b (.clk(clk), .nrst(nrst_b), .bus(if_b));
    led_chaser #(.NUM_LEDS(4), .DIV(4), .LED_ACTIVE_LOW(0)) u_c (.clk(clk), .nrst(nrst_c), .bus(if_c));
    led_chaser #(.NUM_LEDS(4), .DIV(2), .LED_ACTIVE_LOW(1)) u_d (.clk(clk), .nrst(nrst_d), .bus(if_d));
    led_chaser #(.NUM_LEDS(1), .DIV(2), .LED_ACTIVE_LOW(0)) u_e (.clk(clk), .nrst(nrst_e), .bus(if_e));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full DIV=3 period of build A: two quiet cycles then a step
    task automatic a_step(input string tag, input logic [3:0] prev, input logic [3:0] exp);
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            check({tag, "_quiet_step"}, 32'(if_a.step), 32'd0);
            check({tag, "_quiet_led"}, 32'(if_a.led), 32'(prev));
        end
        cyc(1);
        check({tag, "_step"}, 32'(if_a.step), 32'd1);
        check({tag, "_led"}, 32'(if_a.led), 32'(exp));
    endtask

    int   seq_b [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    logic prev_b4;

    initial begin
        nrst_a = 1'b0; nrst_b = 1'b0; nrst_c = 1'b0; nrst_d = 1'b0; nrst_e = 1'b0;
        if_a.mode = 2'd0; if_a.pause = 1'b0;
        if_b.mode = 2'd2; if_b.pause = 1'b0;
        if_c.mode = 2'd3; if_c.pause = 1'b0;
        if_d.mode = 2'd0; if_d.pause = 1'b0;
        if_e.mode = 2'd0; if_e.pause = 1'b0;
        cyc(2);

        // A: rotate up, then switch to rotate down mid-period
        check("a_rst_led", 32'(if_a.led), 32'h0);
        check("a_rst_step", 32'(if_a.step), 32'd0);
        nrst_a = 1'b1;
        a_step("a_up1", 4'b0000, 4'b0001);
        a_step("a_up2", 4'b0001, 4'b0010);
        a_step("a_up3", 4'b0010, 4'b0100);
        a_step("a_up4", 4'b0100, 4'b1000);
        a_step("a_up5", 4'b1000, 4'b0001);
        a_step("a_up6", 4'b0001, 4'b0010);
        a_step("a_up7", 4'b0010, 4'b0100);
        cyc(1);
        if_a.mode = 2'd1;
        cyc(1);
        check("a_sw_hold", 32'(if_a.led), 32'b0100);
        cyc(1);
        check("a_sw_step", 32'(if_a.step), 32'd1);
        check("a_sw_led", 32'(if_a.led), 32'b1000);
        a_step("a_dn1", 4'b1000, 4'b0100);
        a_step("a_dn2", 4'b0100, 4'b0010);
        a_step("a_dn3", 4'b0010, 4'b0001);
        a_step("a_dn4", 4'b0001, 4'b1000);

        // B: bounce on 5 LEDs, a step every cycle
        nrst_b = 1'b1;
        prev_b4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check($sformatf("b_led%0d", i), 32'(if_b.led), 32'd1 << seq_b[i]);
            check($sformatf("b_step%0d", i), 32'(if_b.step), 32'd1);
            check($sformatf("b_end_once%0d", i), 32'(prev_b4 & if_b.led[4]), 32'd0);
            prev_b4 = if_b.led[4];
        end

        // C: blink with pause, then a mode change deferred by pause
        nrst_c = 1'b1;
        cyc(3);
        check("c_pre_led", 32'(if_c.led), 32'h0);
        check("c_pre_step", 32'(if_c.step), 32'd0);
        cyc(1);
        check("c_b1_led", 32'(if_c.led), 32'hF);
        check("c_b1_step", 32'(if_c.step), 32'd1);
        cyc(4);
        check("c_b2_led", 32'(if_c.led), 32'h0);
        cyc(4);
        check("c_b3_led", 32'(if_c.led), 32'hF);
        cyc(3);
        check("c_cnt3_step", 32'(if_c.step), 32'd0);
        if_c.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check($sformatf("c_pz_step%0d", i), 32'(if_c.step), 32'd0);
            check($sformatf("c_pz_led%0d", i), 32'(if_c.led), 32'hF);
        end
        if_c.pause = 1'b0;
        cyc(1);
        check("c_rel_step", 32'(if_c.step), 32'd1);
        check("c_rel_led", 32'(if_c.led), 32'h0);
        cyc(4);
        check("c_b4_led", 32'(if_c.led), 32'hF);
        if_c.pause = 1'b1;
        if_c.mode = 2'd0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check($sformatf("c_pm_led%0d", i), 32'(if_c.led), 32'hF);
            check($sformatf("c_pm_step%0d", i), 32'(if_c.step), 32'd0);
        end
        if_c.pause = 1'b0;
        cyc(3);
        check("c_defer_led", 32'(if_c.led), 32'hF);
        cyc(1);
        check("c_newmode_led", 32'(if_c.led), 32'b0001);
        check("c_newmode_step", 32'(if_c.step), 32'd1);
        cyc(4);
        check("c_newmode2_led", 32'(if_c.led), 32'b0010);

        // D: active-low drive and asynchronous reset
        check("d_rst_led", 32'(if_d.led), 32'hF);
        nrst_d = 1'b1;
        cyc(1);
        check("d_pre_led", 32'(if_d.led), 32'hF);
        cyc(1);
        check("d_s1_led", 32'(if_d.led), 32'b1110);
        check("d_s1_step", 32'(if_d.step), 32'd1);
        cyc(2);
        check("d_s2_led", 32'(if_d.led), 32'b1101);
        #2;
        nrst_d = 1'b0;
        #1;
        check("d_async_led", 32'(if_d.led), 32'hF);
        check("d_async_step", 32'(if_d.step), 32'd0);
        cyc(1);

        // E: single LED stays lit in rotate and bounce modes
        nrst_e = 1'b1;
        cyc(1);
        check("e_pre_led", 32'(if_e.led), 32'd0);
        cyc(1);
        check("e_s1_led", 32'(if_e.led), 32'd1);
        check("e_s1_step", 32'(if_e.step), 32'd1);
        cyc(2);
        check("e_up_led", 32'(if_e.led), 32'd1);
        if_e.mode = 2'd1;
        cyc(2);
        check("e_dn1_led", 32'(if_e.led), 32'd1);
        check("e_dn1_step", 32'(if_e.step), 32'd1);
        cyc(2);
        check("e_dn2_led", 32'(if_e.led), 32'd1);
        if_e.mode = 2'd2;
        cyc(2);
        check("e_bo1_led", 32'(if_e.led), 32'd1);
        cyc(2);
        check("e_bo2_led", 32'(if_e.led), 32'd1);
        check("e_bo2_step", 32'(if_e.step), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
